decode_stage_hz: RTL and testbench
==================================

// Module: decode_stage_hz
// PURPOSE
//  Parametrised ID stage with integrated hazard unit. Sits between the IF/ID and ID/EX boundaries.
//  - Decodes the instruction and drives the register-file read addresses.
//  - Registers operands and decode fields into the ID/EX boundary, with a valid bit.
//  - Detects load-use and multiply RAW hazards and inserts bubbles.
//  - Honours downstream stall and branch flush.
//  - Resolves jumps asynchronously for fetch.
// PARAMETERS
//  ADDR_W      32  PC / immediate width
//  INSTR_W     32  instruction width (decode field positions fixed as per ISA)
//  REG_W       32  register data width
//  REG_ADDR_W   5  register index width
//  MUL_LAT      4  multiply pipe latency in cycles (>=2)
// PORTS
//  clk            in   1           clock, rising edge
//  reset          in   1           asynchronous, active-low reset
//  in_valid       in   1           IF/ID holds a real instruction
//  pc             in   ADDR_W      PC of the instruction in ID
//  instruction    in   INSTR_W     instruction in ID
//  ex_stall       in   1           downstream hold; ID/EX registers keep their values
//  flush          in   1           taken branch from M; kill the instruction entering ID/EX
//  src_reg1       out  REG_ADDR_W  regfile read address 1 = instr[25:21]
//  src_reg2       out  REG_ADDR_W  regfile read address 2 = instr[20:16]
//  rin_reg1       in   REG_W       regfile read data 1
//  rin_reg2       in   REG_W       regfile read data 2
//  hazard_stall   out  1           to fetch: hold PC and IF/ID this cycle
//  out_valid      out  1           ID/EX entry valid
//  out_pc         out  ADDR_W      registered PC
//  rout_reg1      out  REG_W       registered operand 1
//  rout_reg2      out  REG_W       registered operand 2
//  out_addr_reg1  out  REG_ADDR_W  registered source index 1 (for forwarding)
//  out_addr_reg2  out  REG_ADDR_W  registered source index 2; 0 for OP_LDW
//  dest_reg       out  REG_ADDR_W  instr[15:11]; instr[20:16] for OP_STB
//  mimmediat      out  ADDR_W      sign-extended instr[15:0], full ADDR_W
//  op_code        out  6           registered opcode
//  funct_code     out  6           registered funct
//  is_mult        out  1           OP_RTYPE with FN_MUL
//  jump_addr      out  ADDR_W      (pc & 32'hf0000000) | (instr[25:0]<<2), combinational
//  is_jump        out  1           in_valid & opcode==OP_JUMP & !hazard_stall, combinational
// BEHAVIOUR
//  - Reset (reset==0, async):
//    - All registered outputs are 0, including out_valid.
//    - The multiply tracker is IDLE with mul_cnt=0 and mul_dst=0.
//  - ID/EX update (posedge), evaluated in priority order:
//    1. flush: out_valid<=0. Applies even when ex_stall=1.
//    2. ex_stall: all registers hold.
//    3. hazard_stall: bubble. out_valid<=0, is_mult<=0, op_code<=0; other fields don't-care.
//    4. Otherwise: all fields captured, out_valid<=in_valid. Latency is 1 cycle.
//  - A source "uses rs2" unless opcode is OP_LDW or OP_JUMP.
//  - Register index 0 never matches in any hazard comparison.
//  - Load-use hazard, combinational:
//    - Condition: out_valid & op_code==OP_LDW & dest_reg!=0 & (dest_reg==src_reg1 | (uses_rs2 & dest_reg==src_reg2)).
//    - Effect: exactly one bubble. The condition clears once the load advances.
//  - Multiply tracker FSM (IDLE, BUSY):
//    - IDLE->BUSY: a valid mult is captured into ID/EX. mul_cnt<=MUL_LAT-1, mul_dst<=dst.
//    - BUSY: mul_cnt decrements each cycle with !ex_stall. BUSY->IDLE when mul_cnt reaches 0.
//    - Flush does not cancel the tracker; the mult has already issued.
//  - Multiply hazard while BUSY:
//    - RAW: a source matches mul_dst (non-zero) -> hazard_stall.
//    - Structural: the ID instruction is itself a mult -> hazard_stall.
//  - hazard_stall is qualified by in_valid. It is 0 during reset and while flush is asserted.
//  - Simultaneous load-use and multiply hazards produce a single stall signal; no double counting.
//  - Reset asserted mid-stall returns to IDLE immediately; no bubble is carried over.
// TESTING
//  1. Reset low with random inputs -> all outputs 0 and hazard_stall=0. Release -> first valid ADD appears at out_valid one cycle later.
//  2. LDW r3 followed by ADD r4,r3,r5 -> hazard_stall=1 for 1 cycle, one bubble, then ADD captured with out_addr_reg1=3.
//  3. LDW r0 followed by ADD r4,r0,r0 -> no stall. LDW r3 followed by JUMP -> no stall; is_jump=1.
//  4. MUL r7 (MUL_LAT=4) followed by SUB r8,r7,r1 -> 3 stall cycles, then SUB captured. A MUL right after a MUL -> structural stall until IDLE.
//  5. ex_stall=1 for 2 cycles with a hazard pending -> ID/EX and mul_cnt hold. flush with ex_stall -> out_valid=0 next edge.
//  6. JUMP at pc=32'h1000_0040 with imm=26'h10 -> jump_addr=32'h1000_0040, is_jump=1. mimmediat for 16'h8000 = 32'hFFFF_8000.

Source files
------------

// File: rtl/decode_stage_hz_if.sv
// Signal bundle around the decode stage: IF/ID inputs, register-file read port,
// pipeline control, the ID/EX boundary and the jump redirect to fetch.
interface decode_stage_hz_if #(
    parameter int ADDR_W     = 32,
    parameter int INSTR_W    = 32,
    parameter int REG_W      = 32,
    parameter int REG_ADDR_W = 5
);

    logic                  in_valid;
    logic [ADDR_W-1:0]     pc;
    logic [INSTR_W-1:0]    instruction;
    logic                  ex_stall;
    logic                  flush;

    logic [REG_ADDR_W-1:0] src_reg1;
    logic [REG_ADDR_W-1:0] src_reg2;
    logic [REG_W-1:0]      rin_reg1;
    logic [REG_W-1:0]      rin_reg2;

    logic                  hazard_stall;

    logic                  out_valid;
    logic [ADDR_W-1:0]     out_pc;
    logic [REG_W-1:0]      rout_reg1;
    logic [REG_W-1:0]      rout_reg2;
    logic [REG_ADDR_W-1:0] out_addr_reg1;
    logic [REG_ADDR_W-1:0] out_addr_reg2;
    logic [REG_ADDR_W-1:0] dest_reg;
    logic [ADDR_W-1:0]     mimmediat;
    logic [5:0]            op_code;
    logic [5:0]            funct_code;
    logic                  is_mult;

    logic [ADDR_W-1:0]     jump_addr;
    logic                  is_jump;

    // Pipeline / register-file side: drives the ID instruction and control.
    modport master (
        output in_valid, pc, instruction, ex_stall, flush, rin_reg1, rin_reg2,
        input  src_reg1, src_reg2, hazard_stall,
        input  out_valid, out_pc, rout_reg1, rout_reg2, out_addr_reg1, out_addr_reg2,
        input  dest_reg, mimmediat, op_code, funct_code, is_mult,
        input  jump_addr, is_jump
    );

    // Decode stage side.
    modport slave (
        input  in_valid, pc, instruction, ex_stall, flush, rin_reg1, rin_reg2,
        output src_reg1, src_reg2, hazard_stall,
        output out_valid, out_pc, rout_reg1, rout_reg2, out_addr_reg1, out_addr_reg2,
        output dest_reg, mimmediat, op_code, funct_code, is_mult,
        output jump_addr, is_jump
    );

endinterface

// File: rtl/decode_stage_hz.sv
// ID stage: decodes the instruction, registers the ID/EX boundary and inserts
// bubbles for load-use and multiply hazards; resolves jumps combinationally.
module decode_stage_hz #(
    parameter int ADDR_W     = 32,
    parameter int INSTR_W    = 32,
    parameter int REG_W      = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MUL_LAT    = 4
) (
    input logic             clk,
    input logic             reset,
    decode_stage_hz_if.slave bus
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JUMP  = 6'h02;
    localparam logic [5:0] OP_LDW   = 6'h23;
    localparam logic [5:0] OP_STB   = 6'h28;
    localparam logic [5:0] FN_MUL   = 6'h18;

    localparam int CNT_W = $clog2(MUL_LAT);

    typedef enum logic {
        MUL_IDLE,
        MUL_BUSY
    } mul_state_t;

    logic [INSTR_W-1:0]    instr;
    logic [5:0]            id_op;
    logic [5:0]            id_fn;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic [REG_ADDR_W-1:0] id_dst;
    logic [REG_ADDR_W-1:0] id_addr2;
    logic [ADDR_W-1:0]     id_imm;
    logic                  id_is_mult;
    logic                  id_uses_rs2;

    logic                  load_use;
    logic                  mul_raw;
    logic                  mul_struct;
    logic                  hazard;
    logic                  capture;
    logic                  mul_start;

    logic                  valid_q;
    logic [ADDR_W-1:0]     pc_q;
    logic [REG_W-1:0]      rr1_q;
    logic [REG_W-1:0]      rr2_q;
    logic [REG_ADDR_W-1:0] a1_q;
    logic [REG_ADDR_W-1:0] a2_q;
    logic [REG_ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0]     imm_q;
    logic [5:0]            op_q;
    logic [5:0]            fn_q;
    logic                  mult_q;

    mul_state_t            mul_state;
    logic [CNT_W-1:0]      mul_cnt;
    logic [REG_ADDR_W-1:0] mul_dst;

    assign instr       = bus.instruction;
    assign id_op       = instr[31:26];
    assign id_fn       = instr[5:0];
    assign id_rs       = REG_ADDR_W'(instr[25:21]);
    assign id_rt       = REG_ADDR_W'(instr[20:16]);
    assign id_rd       = REG_ADDR_W'(instr[15:11]);
    assign id_is_mult  = (id_op == OP_RTYPE) && (id_fn == FN_MUL);
    assign id_uses_rs2 = (id_op != OP_LDW) && (id_op != OP_JUMP);
    assign id_dst      = (id_op == OP_STB) ? id_rt : id_rd;
    assign id_addr2    = (id_op == OP_LDW) ? '0 : id_rt;
    assign id_imm      = {{(ADDR_W-16){instr[15]}}, instr[15:0]};

    assign bus.src_reg1 = id_rs;
    assign bus.src_reg2 = id_rt;

    // Register 0 is hard-wired, so a zero destination never creates a dependency.
    assign load_use = valid_q && (op_q == OP_LDW) && (dst_q != '0) &&
                      ((dst_q == id_rs) || (id_uses_rs2 && (dst_q == id_rt)));

    assign mul_raw = (mul_state == MUL_BUSY) && (mul_dst != '0) &&
                     ((mul_dst == id_rs) || (id_uses_rs2 && (mul_dst == id_rt)));

    assign mul_struct = (mul_state == MUL_BUSY) && id_is_mult;

    assign hazard = reset && bus.in_valid && !bus.flush &&
                    (load_use || mul_raw || mul_struct);

    assign capture   = !bus.flush && !bus.ex_stall && !hazard;
    assign mul_start = capture && bus.in_valid && id_is_mult;

    assign bus.hazard_stall = hazard;
    assign bus.jump_addr    = {bus.pc[ADDR_W-1:28], instr[25:0], 2'b00};
    assign bus.is_jump      = bus.in_valid && (id_op == OP_JUMP) && !hazard;

    // ID/EX boundary: flush beats ex_stall, which beats the hazard bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rr1_q   <= '0;
            rr2_q   <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            dst_q   <= '0;
            imm_q   <= '0;
            op_q    <= '0;
            fn_q    <= '0;
            mult_q  <= 1'b0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (bus.ex_stall) begin
            valid_q <= valid_q;
        end else if (hazard) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            mult_q  <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            pc_q    <= bus.pc;
            rr1_q   <= bus.rin_reg1;
            rr2_q   <= bus.rin_reg2;
            a1_q    <= id_rs;
            a2_q    <= id_addr2;
            dst_q   <= id_dst;
            imm_q   <= id_imm;
            op_q    <= id_op;
            fn_q    <= id_fn;
            mult_q  <= id_is_mult;
        end
    end

    // Multiply tracker; a flush does not cancel it because the mult already issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_state <= MUL_IDLE;
            mul_cnt   <= '0;
            mul_dst   <= '0;
        end else begin
            case (mul_state)
                MUL_IDLE: begin
                    if (mul_start) begin
                        mul_state <= MUL_BUSY;
                        mul_cnt   <= CNT_W'(MUL_LAT - 1);
                        mul_dst   <= id_dst;
                    end
                end
                MUL_BUSY: begin
                    if (!bus.ex_stall) begin
                        mul_cnt <= mul_cnt - CNT_W'(1);
                        if (mul_cnt == CNT_W'(1)) begin
                            mul_state <= MUL_IDLE;
                        end
                    end
                end
                default: begin
                    mul_state <= MUL_IDLE;
                    mul_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.out_valid     = valid_q;
    assign bus.out_pc        = pc_q;
    assign bus.rout_reg1     = rr1_q;
    assign bus.rout_reg2     = rr2_q;
    assign bus.out_addr_reg1 = a1_q;
    assign bus.out_addr_reg2 = a2_q;
    assign bus.dest_reg      = dst_q;
    assign bus.mimmediat     = imm_q;
    assign bus.op_code       = op_q;
    assign bus.funct_code    = fn_q;
    assign bus.is_mult       = mult_q;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed bench for decode_stage_hz: a per-cycle vector table for decode,
// load-use, flush and jump behaviour, plus hand sequences for multiply hazards.
module tb_decode_stage_hz;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JUMP  = 6'h02;
    localparam logic [5:0] OP_LDW   = 6'h23;
    localparam logic [5:0] OP_STB   = 6'h28;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_MUL   = 6'h18;
    localparam int         NVEC     = 17;

    typedef struct {
        logic        iv;
        logic        fl;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        e_hs;
        logic        e_ij;
        logic [31:0] e_ja;
        logic        e_ov;
        logic        full;
        logic [5:0]  e_op;
        logic [5:0]  e_fn;
        logic [4:0]  e_a1;
        logic [4:0]  e_a2;
        logic [4:0]  e_dst;
        logic [31:0] e_imm;
        logic        e_mult;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   n_stall;
    vec_t vecs [NVEC];

    decode_stage_hz_if #(.ADDR_W(32), .INSTR_W(32), .REG_W(32), .REG_ADDR_W(5)) bus ();

    decode_stage_hz #(
        .ADDR_W(32), .INSTR_W(32), .REG_W(32), .REG_ADDR_W(5), .MUL_LAT(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] jtype(input logic [25:0] tgt);
        return {OP_JUMP, tgt};
    endfunction

    function automatic vec_t make_vec(
        input logic iv, input logic fl, input logic [31:0] pc, input logic [31:0] instr,
        input logic [31:0] r1, input logic [31:0] r2,
        input logic hs, input logic ij, input logic [31:0] ja,
        input logic ov, input logic full, input logic [5:0] op, input logic [5:0] fn,
        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] dst,
        input logic [31:0] imm, input logic mult);
        vec_t v;
        v.iv = iv;  v.fl = fl;  v.pc = pc;  v.instr = instr;  v.r1 = r1;  v.r2 = r2;
        v.e_hs = hs;  v.e_ij = ij;  v.e_ja = ja;  v.e_ov = ov;  v.full = full;
        v.e_op = op;  v.e_fn = fn;  v.e_a1 = a1;  v.e_a2 = a2;  v.e_dst = dst;
        v.e_imm = imm;  v.e_mult = mult;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [31:0] instr,
                                 input logic [31:0] pc, input logic [31:0] r1,
                                 input logic [31:0] r2, input logic exs, input logic fl);
        bus.in_valid    = iv;
        bus.instruction = instr;
        bus.pc          = pc;
        bus.rin_reg1    = r1;
        bus.rin_reg2    = r2;
        bus.ex_stall    = exs;
        bus.flush       = fl;
    endtask

    // Counts stall cycles with inputs held; each stalled edge must leave a bubble.
    task automatic wait_stall_clear(output int n);
        n = 0;
        #1;
        while (bus.hazard_stall === 1'b1 && n < 20) begin
            n++;
            @(posedge clk); #1;
            checkOutput("bubble_valid", 32'(bus.out_valid), 32'd0);
            @(negedge clk); #1;
        end
        if (n >= 20) checkOutput("stall_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = make_vec(1, 0, 32'h100, rtype(1, 2, 4, FN_ADD), 32'hA0, 32'hB0,
                            0, 0, 0, 1, 1, 6'h00, 6'h20, 1, 2, 4, 32'h2020, 0);
        vecs[1]  = make_vec(1, 0, 32'h104, itype(OP_LDW, 2, 9, 16'h1804), 32'hA1, 32'hB1,
                            0, 0, 0, 1, 1, 6'h23, 6'h04, 2, 0, 3, 32'h1804, 0);
        vecs[2]  = make_vec(1, 0, 32'h108, rtype(3, 5, 4, FN_ADD), 32'hA2, 32'hB2,
                            1, 0, 0, 0, 0, 6'h00, 6'h00, 0, 0, 0, 32'h0, 0);
        vecs[3]  = make_vec(1, 0, 32'h108, rtype(3, 5, 4, FN_ADD), 32'hA3, 32'hB3,
                            0, 0, 0, 1, 1, 6'h00, 6'h20, 3, 5, 4, 32'h2020, 0);
        vecs[4]  = make_vec(1, 0, 32'h10C, itype(OP_LDW, 1, 0, 16'h0010), 32'hA4, 32'hB4,
                            0, 0, 0, 1, 1, 6'h23, 6'h10, 1, 0, 0, 32'h10, 0);
        vecs[5]  = make_vec(1, 0, 32'h110, rtype(0, 0, 4, FN_ADD), 32'hA5, 32'hB5,
                            0, 0, 0, 1, 1, 6'h00, 6'h20, 0, 0, 4, 32'h2020, 0);
        vecs[6]  = make_vec(1, 0, 32'h114, itype(OP_LDW, 2, 9, 16'h1804), 32'hA6, 32'hB6,
                            0, 0, 0, 1, 1, 6'h23, 6'h04, 2, 0, 3, 32'h1804, 0);
        vecs[7]  = make_vec(1, 0, 32'h1000_0040, jtype(26'h10), 32'hA7, 32'hB7,
                            0, 1, 32'h1000_0040, 1, 1, 6'h02, 6'h10, 0, 0, 0, 32'h10, 0);
        vecs[8]  = make_vec(1, 0, 32'h118, itype(OP_LDW, 2, 9, 16'h1804), 32'hA8, 32'hB8,
                            0, 0, 0, 1, 1, 6'h23, 6'h04, 2, 0, 3, 32'h1804, 0);
        vecs[9]  = make_vec(1, 0, 32'h11C, itype(OP_STB, 1, 3, 16'h0008), 32'hA9, 32'hB9,
                            1, 0, 0, 0, 0, 6'h00, 6'h00, 0, 0, 0, 32'h0, 0);
        vecs[10] = make_vec(1, 0, 32'h11C, itype(OP_STB, 1, 3, 16'h0008), 32'hAA, 32'hBA,
                            0, 0, 0, 1, 1, 6'h28, 6'h08, 1, 3, 3, 32'h8, 0);
        vecs[11] = make_vec(1, 1, 32'h120, rtype(1, 2, 6, FN_ADD), 32'hAB, 32'hBB,
                            0, 0, 0, 0, 0, 6'h00, 6'h00, 0, 0, 0, 32'h0, 0);
        vecs[12] = make_vec(1, 0, 32'h124, itype(OP_LDW, 2, 9, 16'h1804), 32'hAC, 32'hBC,
                            0, 0, 0, 1, 1, 6'h23, 6'h04, 2, 0, 3, 32'h1804, 0);
        vecs[13] = make_vec(1, 1, 32'h128, rtype(3, 5, 4, FN_ADD), 32'hAD, 32'hBD,
                            0, 0, 0, 0, 0, 6'h00, 6'h00, 0, 0, 0, 32'h0, 0);
        vecs[14] = make_vec(1, 0, 32'h128, rtype(3, 5, 4, FN_ADD), 32'hAE, 32'hBE,
                            0, 0, 0, 1, 1, 6'h00, 6'h20, 3, 5, 4, 32'h2020, 0);
        vecs[15] = make_vec(1, 0, 32'h12C, itype(OP_LDW, 1, 2, 16'h8000), 32'hAF, 32'hBF,
                            0, 0, 0, 1, 1, 6'h23, 6'h00, 1, 0, 16, 32'hFFFF_8000, 0);
        vecs[16] = make_vec(0, 0, 32'h130, rtype(16, 0, 5, FN_ADD), 32'hC0, 32'hD0,
                            0, 0, 0, 0, 0, 6'h00, 6'h00, 0, 0, 0, 32'h0, 0);

        // Reset held with random inputs.
        reset = 1'b0;
        applyStimulus(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            applyStimulus(1'($urandom), $urandom, $urandom, $urandom, $urandom,
                          1'($urandom), 1'($urandom));
            #1;
            checkOutput("rst_hazard_stall", 32'(bus.hazard_stall), 32'd0);
            @(posedge clk); #1;
            checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
            checkOutput("rst_out_pc", bus.out_pc, 32'd0);
            checkOutput("rst_rout_reg1", bus.rout_reg1, 32'd0);
            checkOutput("rst_rout_reg2", bus.rout_reg2, 32'd0);
            checkOutput("rst_op_code", 32'(bus.op_code), 32'd0);
            checkOutput("rst_dest_reg", 32'(bus.dest_reg), 32'd0);
            checkOutput("rst_mimmediat", bus.mimmediat, 32'd0);
            checkOutput("rst_is_mult", 32'(bus.is_mult), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].iv, vecs[i].instr, vecs[i].pc, vecs[i].r1, vecs[i].r2,
                          1'b0, vecs[i].fl);
            #1;
            checkOutput($sformatf("v%0d_hazard_stall", i), 32'(bus.hazard_stall), 32'(vecs[i].e_hs));
            checkOutput($sformatf("v%0d_is_jump", i), 32'(bus.is_jump), 32'(vecs[i].e_ij));
            if (vecs[i].e_ij)
                checkOutput($sformatf("v%0d_jump_addr", i), bus.jump_addr, vecs[i].e_ja);
            @(posedge clk); #1;
            checkOutput($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
            if (vecs[i].full) begin
                checkOutput($sformatf("v%0d_out_pc", i), bus.out_pc, vecs[i].pc);
                checkOutput($sformatf("v%0d_rout_reg1", i), bus.rout_reg1, vecs[i].r1);
                checkOutput($sformatf("v%0d_rout_reg2", i), bus.rout_reg2, vecs[i].r2);
                checkOutput($sformatf("v%0d_op_code", i), 32'(bus.op_code), 32'(vecs[i].e_op));
                checkOutput($sformatf("v%0d_funct", i), 32'(bus.funct_code), 32'(vecs[i].e_fn));
                checkOutput($sformatf("v%0d_addr1", i), 32'(bus.out_addr_reg1), 32'(vecs[i].e_a1));
                checkOutput($sformatf("v%0d_addr2", i), 32'(bus.out_addr_reg2), 32'(vecs[i].e_a2));
                checkOutput($sformatf("v%0d_dest", i), 32'(bus.dest_reg), 32'(vecs[i].e_dst));
                checkOutput($sformatf("v%0d_imm", i), bus.mimmediat, vecs[i].e_imm);
                checkOutput($sformatf("v%0d_is_mult", i), 32'(bus.is_mult), 32'(vecs[i].e_mult));
            end else if (!vecs[i].fl) begin
                checkOutput($sformatf("v%0d_bubble_op", i), 32'(bus.op_code), 32'd0);
                checkOutput($sformatf("v%0d_bubble_mult", i), 32'(bus.is_mult), 32'd0);
            end
        end

        // MUL r7 then dependent SUB: three stall cycles at MUL_LAT=4.
        @(negedge clk);
        applyStimulus(1, rtype(1, 2, 7, FN_MUL), 32'h200, 32'h1, 32'h2, 0, 0);
        #1 checkOutput("mul_issue_stall", 32'(bus.hazard_stall), 32'd0);
        @(posedge clk); #1;
        checkOutput("mul_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("mul_is_mult", 32'(bus.is_mult), 32'd1);
        checkOutput("mul_dest", 32'(bus.dest_reg), 32'd7);
        @(negedge clk);
        applyStimulus(1, rtype(7, 1, 8, FN_SUB), 32'h204, 32'h3, 32'h4, 0, 0);
        wait_stall_clear(n_stall);
        checkOutput("raw_stall_cycles", 32'(n_stall), 32'd3);
        checkOutput("raw_bubble_mult", 32'(bus.is_mult), 32'd0);
        @(posedge clk); #1;
        checkOutput("sub_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("sub_funct", 32'(bus.funct_code), 32'(FN_SUB));
        checkOutput("sub_addr1", 32'(bus.out_addr_reg1), 32'd7);
        checkOutput("sub_dest", 32'(bus.dest_reg), 32'd8);

        // Back-to-back multiplies: structural stall, then an independent ADD flows.
        @(negedge clk);
        applyStimulus(1, rtype(1, 2, 9, FN_MUL), 32'h208, 32'h5, 32'h6, 0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        applyStimulus(1, rtype(3, 4, 10, FN_MUL), 32'h20C, 32'h7, 32'h8, 0, 0);
        wait_stall_clear(n_stall);
        checkOutput("struct_stall_cycles", 32'(n_stall), 32'd3);
        @(posedge clk); #1;
        checkOutput("mul2_is_mult", 32'(bus.is_mult), 32'd1);
        checkOutput("mul2_dest", 32'(bus.dest_reg), 32'd10);
        @(negedge clk);
        applyStimulus(1, rtype(1, 2, 11, FN_ADD), 32'h210, 32'h9, 32'hA, 0, 0);
        #1 checkOutput("indep_no_stall", 32'(bus.hazard_stall), 32'd0);
        @(posedge clk); #1;
        checkOutput("indep_valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        applyStimulus(0, 32'h0, 32'h214, 32'h0, 32'h0, 0, 0);
        repeat (4) @(negedge clk);

        // Load-use and multiply RAW together: only two stalls, no double count.
        applyStimulus(1, rtype(1, 2, 7, FN_MUL), 32'h300, 32'h1, 32'h2, 0, 0);
        @(negedge clk);
        applyStimulus(1, itype(OP_LDW, 1, 0, 16'h2800), 32'h304, 32'h3, 32'h4, 0, 0);
        #1 checkOutput("ldw_in_busy_stall", 32'(bus.hazard_stall), 32'd0);
        @(negedge clk);
        applyStimulus(1, rtype(5, 7, 12, FN_ADD), 32'h308, 32'h5, 32'h6, 0, 0);
        wait_stall_clear(n_stall);
        checkOutput("combined_stall_cycles", 32'(n_stall), 32'd2);
        @(posedge clk); #1;
        checkOutput("combined_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("combined_addr1", 32'(bus.out_addr_reg1), 32'd5);

        // ex_stall during a pending multiply hazard freezes ID/EX and the count.
        @(negedge clk);
        applyStimulus(1, rtype(1, 2, 7, FN_MUL), 32'h400, 32'h1, 32'h2, 0, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            applyStimulus(1, rtype(7, 1, 8, FN_SUB), 32'h404, 32'h3, 32'h4, 1, 0);
            #1 checkOutput("exs_hazard", 32'(bus.hazard_stall), 32'd1);
            @(posedge clk); #1;
            checkOutput("exs_hold_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("exs_hold_funct", 32'(bus.funct_code), 32'(FN_MUL));
            checkOutput("exs_hold_pc", bus.out_pc, 32'h400);
        end
        @(negedge clk);
        applyStimulus(1, rtype(7, 1, 8, FN_SUB), 32'h404, 32'h3, 32'h4, 0, 0);
        wait_stall_clear(n_stall);
        checkOutput("exs_remaining_stalls", 32'(n_stall), 32'd3);
        @(posedge clk); #1;
        checkOutput("exs_sub_funct", 32'(bus.funct_code), 32'(FN_SUB));
        @(negedge clk);
        applyStimulus(1, rtype(1, 2, 3, FN_ADD), 32'h408, 32'h5, 32'h6, 1, 1);
        @(posedge clk); #1;
        checkOutput("flush_over_exs_valid", 32'(bus.out_valid), 32'd0);

        // Reset in the middle of a multiply stall.
        @(negedge clk);
        applyStimulus(1, rtype(1, 2, 7, FN_MUL), 32'h500, 32'h1, 32'h2, 0, 0);
        @(negedge clk);
        applyStimulus(1, rtype(7, 1, 8, FN_SUB), 32'h504, 32'h3, 32'h4, 0, 0);
        #1 checkOutput("pre_reset_stall", 32'(bus.hazard_stall), 32'd1);
        #1 reset = 1'b0;
        #1;
        checkOutput("mid_reset_stall", 32'(bus.hazard_stall), 32'd0);
        checkOutput("mid_reset_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1 checkOutput("post_reset_stall", 32'(bus.hazard_stall), 32'd0);
        @(posedge clk); #1;
        checkOutput("post_reset_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("post_reset_funct", 32'(bus.funct_code), 32'(FN_SUB));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
